// File: rtl/rd_ptr_burst.sv
// rd_ptr_burst: read-side pointer controller for a single-clock FIFO that can
// pop 1..MAX_RD words per handshake.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   o_tvalid        at least one word is poppable (registered)
//   i_tready        consumer accepts this cycle
//   o_tcount        words presented, min(level, MAX_RD) (registered)
//   i_rcount        words consumed on a handshake
//   i_flush         discard all stored words (read pointer jumps to write pointer)
//   o_raddr         MAX_RD look-ahead RAM read addresses, lane k at [k*ALEN +: ALEN]
//   o_rptr          registered binary read pointer (ALEN+1 bits incl. wrap bit)
//   i_wptr          write pointer from the write side
//   o_level         registered occupancy, 0..2**ALEN
//   o_almost_empty  registered, level <= AE_THRESH
//   o_err           sticky overrun flag (consumer asked for more than presented)
//
// Optional feature macro FIFO_RD_GRAY_PTR_EN adds o_rptr_gray, the registered
// Gray-coded read pointer for a future asynchronous write side.
module rd_ptr_burst #(
    parameter int unsigned ALEN      = 8,
    parameter int unsigned MAX_RD    = 4,
    parameter int unsigned AE_THRESH = 2,
    localparam int unsigned CW       = $clog2(MAX_RD + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   o_tvalid,
    input  logic                   i_tready,
    output logic [CW-1:0]          o_tcount,
    input  logic [CW-1:0]          i_rcount,
    input  logic                   i_flush,
    output logic [MAX_RD*ALEN-1:0] o_raddr,
    output logic [ALEN:0]          o_rptr,
    input  logic [ALEN:0]          i_wptr,
    output logic [ALEN:0]          o_level,
    output logic                   o_almost_empty,
    output logic                   o_err
`ifdef FIFO_RD_GRAY_PTR_EN
    ,
    output logic [ALEN:0]          o_rptr_gray
`endif
);

    localparam int unsigned PW = ALEN + 1;

    logic          hs;
    logic          over;
    logic [CW-1:0] pop;
    logic [PW-1:0] rptr_d;
    logic [PW-1:0] lvl_d;
    logic [CW-1:0] tcount_d;

    always_comb begin
        hs   = o_tvalid & i_tready;
        over = hs && (i_rcount > o_tcount);
        pop  = '0;
        if (hs) begin
            pop = over ? o_tcount : i_rcount;
        end

        // Reset forces the next pointer to zero so look-ahead addresses and the
        // first post-reset level are computed against rptr = 0.
        if (rst) begin
            rptr_d = '0;
        end else if (i_flush) begin
            rptr_d = i_wptr;
        end else begin
            rptr_d = o_rptr + PW'(pop);
        end

        // Wrap bit makes the modular difference exact up to a full FIFO.
        lvl_d    = i_wptr - rptr_d;
        tcount_d = (lvl_d > PW'(MAX_RD)) ? CW'(MAX_RD) : CW'(lvl_d);

        // Addresses come from the next pointer so a 1-cycle registered RAM read
        // lines up with the updated o_rptr.
        o_raddr = '0;
        for (int unsigned k = 0; k < MAX_RD; k++) begin
            o_raddr[k*ALEN +: ALEN] = rptr_d[ALEN-1:0] + ALEN'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_rptr         <= '0;
            o_level        <= '0;
            o_tvalid       <= 1'b0;
            o_tcount       <= '0;
            o_almost_empty <= 1'b1;
            o_err          <= 1'b0;
        end else begin
            o_rptr         <= rptr_d;
            o_level        <= lvl_d;
            o_tvalid       <= (lvl_d != '0);
            o_tcount       <= tcount_d;
            o_almost_empty <= (lvl_d <= PW'(AE_THRESH));
            if (over) begin
                o_err <= 1'b1;
            end
        end
    end

`ifdef FIFO_RD_GRAY_PTR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rptr_gray <= '0;
        end else begin
            o_rptr_gray <= rptr_d ^ (rptr_d >> 1);
        end
    end
`else
    // Binary pointer only; no Gray-coded copy is kept.
`endif

endmodule

// File: tb/tb_rd_ptr_burst.sv
module tb_rd_ptr_burst;

    localparam int ALEN  = 4;
    localparam int MAXRD = 4;
    localparam int AE    = 2;
    localparam int CW    = 3;
    localparam int DEPTH = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    o_tvalid;
    logic                    i_tready;
    logic [CW-1:0]           o_tcount;
    logic [CW-1:0]           i_rcount;
    logic                    i_flush;
    logic [MAXRD*ALEN-1:0]   o_raddr;
    logic [ALEN:0]           o_rptr;
    logic [ALEN:0]           i_wptr;
    logic [ALEN:0]           o_level;
    logic                    o_almost_empty;
    logic                    o_err;
`ifdef FIFO_RD_GRAY_PTR_EN
    logic [ALEN:0]           o_rptr_gray;
`endif

    always #5 clk = ~clk;

    rd_ptr_burst #(
        .ALEN      (ALEN),
        .MAX_RD    (MAXRD),
        .AE_THRESH (AE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .o_tvalid       (o_tvalid),
        .i_tready       (i_tready),
        .o_tcount       (o_tcount),
        .i_rcount       (i_rcount),
        .i_flush        (i_flush),
        .o_raddr        (o_raddr),
        .o_rptr         (o_rptr),
        .i_wptr         (i_wptr),
        .o_level        (o_level),
        .o_almost_empty (o_almost_empty),
        .o_err          (o_err)
`ifdef FIFO_RD_GRAY_PTR_EN
        ,
        .o_rptr_gray    (o_rptr_gray)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is just "words between read and write pointer".
    logic [4:0] m_rptr  = '0;
    logic [4:0] m_wseen = '0;
    bit         m_rst   = 1'b1;
    bit         m_err   = 1'b0;
    bit         started = 1'b0;

    function automatic int e_level();
        logic [4:0] d;
        if (m_rst) return 0;
        d = m_wseen - m_rptr;
        return int'(d);
    endfunction

    function automatic int e_tcount();
        int l;
        l = e_level();
        return (l < MAXRD) ? l : MAXRD;
    endfunction

    function automatic int e_pop();
        int tc;
        tc = e_tcount();
        if (!((tc != 0) && i_tready)) return 0;
        return (int'(i_rcount) < tc) ? int'(i_rcount) : tc;
    endfunction

    function automatic bit e_over();
        return (e_tcount() != 0) && i_tready && (int'(i_rcount) > e_tcount());
    endfunction

    function automatic logic [4:0] e_next_rptr();
        if (i_flush) return i_wptr;
        return m_rptr + 5'(e_pop());
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_rptr  <= '0;
            m_err   <= 1'b0;
            m_rst   <= 1'b1;
            started <= 1'b1;
        end else begin
            if (e_over()) m_err <= 1'b1;
            m_rptr  <= e_next_rptr();
            m_wseen <= i_wptr;
            m_rst   <= 1'b0;
        end
    end

    // Compare process: every cycle once reset has been seen.
    always @(negedge clk) begin
        if (started) begin
            logic [4:0] rd;
            logic [3:0] la;
            chk("model_rptr", o_rptr, int'(m_rptr));
            chk("model_level", o_level, e_level());
            chk("model_tvalid", o_tvalid, int'(e_level() != 0));
            chk("model_tcount", o_tcount, e_tcount());
            chk("model_almost_empty", o_almost_empty, int'(e_level() <= AE));
            chk("model_err", o_err, int'(m_err));
            if (!rst) begin
                rd = e_next_rptr();
                for (int k = 0; k < MAXRD; k++) begin
                    la = rd[3:0] + 4'(k);
                    chk("model_raddr", o_raddr[k*ALEN +: ALEN], int'(la));
                end
            end
        end
    end

    task automatic set_in(input bit r, input int w, input bit tr, input int rc, input bit fl);
        rst      = r;
        i_wptr   = 5'(w);
        i_tready = tr;
        i_rcount = 3'(rc);
        i_flush  = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        set_in(1, 7, 0, 0, 0);
        step();
        step();
        // Reset state with i_wptr = 7
        chk("rst_rptr", o_rptr, 0);
        chk("rst_tvalid", o_tvalid, 0);
        chk("rst_level", o_level, 0);
        chk("rst_ae", o_almost_empty, 1);
        chk("rst_err", o_err, 0);
        set_in(0, 7, 0, 0, 0);
        step();
        chk("post_rst_level", o_level, 7);
        chk("post_rst_tcount", o_tcount, 4);
        chk("post_rst_tvalid", o_tvalid, 1);

        // Burst pops with clamp on the second handshake
        set_in(1, 6, 0, 0, 0);
        step();
        set_in(0, 6, 0, 0, 0);
        step();
        set_in(0, 6, 1, 4, 0);
        #1;
        chk("burst_raddr0_a", o_raddr[3:0], 4);
        step();
        chk("burst_rptr_a", o_rptr, 4);
        chk("burst_tcount_a", o_tcount, 2);
        chk("burst_err_a", o_err, 0);
        #1;
        chk("burst_raddr0_b", o_raddr[3:0], 6);
        step();
        chk("burst_rptr_b", o_rptr, 6);
        chk("burst_err_b", o_err, 1);
        chk("burst_tvalid_b", o_tvalid, 0);

        // Wrap: flush to 30, write up to 2, pop 3
        set_in(1, 0, 0, 0, 0);
        step();
        set_in(0, 30, 0, 0, 1);
        step();
        chk("wrap_preload", o_rptr, 30);
        set_in(0, 2, 0, 0, 0);
        step();
        chk("wrap_level4", o_level, 4);
        set_in(0, 2, 1, 3, 0);
        #1;
        chk("wrap_raddr0", o_raddr[3:0], 1);
        chk("wrap_raddr1", o_raddr[7:4], 2);
        step();
        chk("wrap_rptr", o_rptr, 1);
        chk("wrap_level", o_level, 1);
        chk("wrap_ae", o_almost_empty, 1);

        // Full plus simultaneous write and pop
        set_in(1, 16, 0, 0, 0);
        step();
        set_in(0, 16, 0, 0, 0);
        step();
        chk("full_level", o_level, 16);
        chk("full_tcount", o_tcount, 4);
        set_in(0, 17, 1, 2, 0);
        step();
        chk("full_rw_level", o_level, 15);
        chk("full_rw_tcount", o_tcount, 4);
        chk("full_rw_rptr", o_rptr, 2);

        // Flush beats a concurrent handshake
        set_in(1, 0, 0, 0, 0);
        step();
        set_in(0, 9, 0, 0, 0);
        step();
        chk("flush_pre_level", o_level, 9);
        set_in(0, 9, 1, 3, 1);
        step();
        chk("flush_rptr", o_rptr, 9);
        chk("flush_level", o_level, 0);
        chk("flush_tvalid", o_tvalid, 0);
        chk("flush_err", o_err, 0);

`ifdef FIFO_RD_GRAY_PTR_EN
        set_in(0, 7, 0, 0, 1);
        step();
        chk("gray_7", o_rptr_gray, 'h04);
        set_in(0, 12, 0, 0, 0);
        step();
        set_in(0, 12, 1, 1, 0);
        step();
        chk("gray_rptr8", o_rptr, 8);
        chk("gray_8", o_rptr_gray, 'h0C);
`endif

        // Randomized phase, keeping the write side legal (level never above DEPTH)
        for (int i = 0; i < 3000; i++) begin
            int         r;
            int         l;
            int         adv;
            int         rc;
            logic [4:0] d;
            r = $urandom_range(0, 99);
            d = i_wptr - m_rptr;
            l = int'(d);
            if (r < 2) begin
                set_in(1, $urandom_range(0, DEPTH), $urandom_range(0, 1), $urandom_range(0, 4), 0);
            end else begin
                adv = $urandom_range(0, ((DEPTH - l) < 3) ? (DEPTH - l) : 3);
                if ($urandom_range(0, 19) == 0) rc = $urandom_range(0, 7);
                else rc = $urandom_range(0, e_tcount());
                set_in(0, int'(i_wptr) + adv, $urandom_range(0, 1), rc, (r < 6));
            end
            step();
        end

        set_in(0, int'(i_wptr), 0, 0, 0);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
